// File: rtl/bmf_max_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bmf_max_pkg
//  Description : Shared types, mode constants and helpers for the streaming
//                max tracker with approximate/exact comparators.
//  Revision    : 1.0 - initial release
// ============================================================================
package bmf_max_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] w_lim;
        w_lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= w_lim) ? w_lim : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmf_max_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : bmf_max_cmp
//  Description : Strict greater-than compare of a candidate against the
//                incumbent; full-width when exact, top-K MSBs when approximate.
//  Revision    : 1.0 - initial release
// ============================================================================
module bmf_max_cmp #(
    parameter int WIDTH = 8,
    parameter int K     = 4
) (
    input  logic [WIDTH-1:0] cand,
    input  logic [WIDTH-1:0] incumbent,
    input  logic             approx,
    output logic             take
);

    logic w_take_full;
    logic w_take_msb;

    // Strict compares: ties keep the incumbent in both paths.
    assign w_take_full = (cand > incumbent);
    assign w_take_msb  = (cand[WIDTH-1 -: K] > incumbent[WIDTH-1 -: K]);
    assign take        = approx ? w_take_msb : w_take_full;

endmodule
`default_nettype wire

// File: rtl/bmf_max_stream.sv
`default_nettype none
// ============================================================================
//  Module      : bmf_max_stream
//  Description : Per-packet max tracker; reports the active comparator's max
//                together with mismatch count and error versus an exact shadow.
//  Revision    : 1.0 - initial release
// ============================================================================
module bmf_max_stream
    import bmf_max_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [LEN_W-1:0] out_count,
    output logic [LEN_W-1:0] out_mismatch,
    output logic [WIDTH-1:0] out_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode;
    logic [WIDTH-1:0] r_apx_max;
    logic [WIDTH-1:0] r_exact_max;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_mismatch;

    logic             w_accept;
    logic             w_apx_take;
    logic             w_exact_take;

    bmf_max_cmp #(.WIDTH(WIDTH), .K(K)) u_cmp_apx (
        .cand      (in_data),
        .incumbent (r_apx_max),
        .approx    (r_mode),
        .take      (w_apx_take)
    );

    bmf_max_cmp #(.WIDTH(WIDTH), .K(K)) u_cmp_exact (
        .cand      (in_data),
        .incumbent (r_exact_max),
        .approx    (MODE_EXACT),
        .take      (w_exact_take)
    );

    assign w_accept = in_valid & in_ready;

    // in_ready depends on state only, so out_ready never reaches it combinationally.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = in_last ? EMIT : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last)
                    w_state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_apx_max   <= '0;
            r_exact_max <= '0;
            r_count     <= '0;
            r_mismatch  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (r_state == IDLE) begin
                    r_mode      <= mode;
                    r_apx_max   <= in_data;
                    r_exact_max <= in_data;
                    r_count     <= LEN_W'(1);
                    r_mismatch  <= '0;
                end else begin
                    if (w_apx_take)
                        r_apx_max <= in_data;
                    if (w_exact_take)
                        r_exact_max <= in_data;
                    r_count <= LEN_W'(sat_inc(32'(r_count), LEN_W));
                    if (w_apx_take != w_exact_take)
                        r_mismatch <= LEN_W'(sat_inc(32'(r_mismatch), LEN_W));
                end
            end
        end
    end

    // The exact max never falls below the approximate one, so this cannot wrap.
    assign out_max      = r_apx_max;
    assign out_err      = r_exact_max - r_apx_max;
    assign out_count    = r_count;
    assign out_mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: doc/bmf_max_stream.md
Name: bmf_max_stream

Overview:
- Streaming, parametrised successor to the rank-K factorised max partitions.
- Tracks the maximum of each packet of WIDTH-bit values with a valid/ready handshake.
- Runs an approximate comparator (top-K-bit compare) in parallel with an exact shadow comparator.
- Per packet, emits the approximate max plus error metrics (mismatch count, numeric error), so the approximation flow can measure quality in hardware.

Parameters:
WIDTH, 8, data width of each input element
K, 4, number of MSBs used by the approximate comparator (1 <= K <= WIDTH)
LEN_W, 8, width of the beat counter and mismatch counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
mode  input  1  0 = exact, 1 = approximate; sampled on the first accepted beat of a packet
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  element value (unsigned)
in_last  input  1  final beat of the packet
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_max  output  WIDTH  max chosen by the active comparator
out_count  output  LEN_W  beats in the packet, saturating
out_mismatch  output  LEN_W  beats where the approximate and exact decisions differed, saturating
out_err  output  WIDTH  exact_max minus out_max (always >= 0)

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All registers and outputs 0, except in_ready = 1 once the state is IDLE.
  - Reset mid-packet discards the partial packet; no output is produced for it.
- FSM states: IDLE, ACCUM, EMIT.
- IDLE:
  - in_ready = 1.
  - On accept (in_valid & in_ready):
    - mode_q = mode; apx_max = exact_max = in_data; count = 1; mismatch = 0.
    - Next state is EMIT if in_last, else ACCUM.
- ACCUM:
  - in_ready = 1.
  - On accept:
    - exact_take = in_data > exact_max, full WIDTH compare.
    - apx_take depends on mode_q:
      - mode_q = 1: apx_take = in_data[WIDTH-1 -: K] > apx_max[WIDTH-1 -: K].
      - mode_q = 0: apx_take = in_data > apx_max.
    - On a tie, the incumbent is kept (strict compare in both paths).
    - Update each max if its take bit is set.
    - count += 1, saturating at 2^LEN_W-1.
    - mismatch += (apx_take != exact_take), saturating.
    - in_last moves the state to EMIT.
  - No accept: hold.
- EMIT:
  - in_ready = 0; out_valid = 1.
  - Output fields come straight from registers and are stable while out_valid & !out_ready.
  - out_err = exact_max - apx_max, WIDTH-bit unsigned, no wrap possible.
  - out_valid & out_ready moves the state to IDLE; out_valid deasserts the next cycle.
- Latency and throughput:
  - out_valid rises on the cycle after the last beat is accepted.
  - Minimum packet period is L+1 cycles for an L-beat packet (one bubble for EMIT).
- Single-beat packet: IDLE goes directly to EMIT, with count = 1, mismatch = 0, err = 0.
- mode changes mid-packet are ignored; only mode_q is used.
- With mode_q = 0, mismatch and out_err are necessarily 0.
- in_data, in_last and mode are don't-care when in_valid = 0.
- No combinational path from out_ready to in_ready. in_ready is a function of state only.
- K = WIDTH makes the approximate path identical to the exact path.

Decomposition:
- Package bmf_max_pkg:
  - state enum {IDLE, ACCUM, EMIT}.
  - Mode constants MODE_EXACT = 0, MODE_APPROX = 1.
  - A saturating-increment function parametrised by width.
- Sub-module bmf_max_cmp (combinational, params WIDTH and K):
  - inputs cand, incumbent, approx.
  - output take.
  - Instantiated twice: once with approx tied to mode_q, once with approx tied to 0 for the exact shadow.

Test Plan:
- WIDTH=8, K=4, mode=1, packet [0x35, 0x3A, 0x31(last)] -> out_max = 0x35, out_count = 3, out_mismatch = 1, out_err = 0x05, out_valid 1 cycle after last accept.
- Same packet with mode=0 -> out_max = 0x3A, out_mismatch = 0, out_err = 0.
- Single beat 0xF0 with last, mode=1 -> out_max = 0xF0, count = 1, mismatch = 0, err = 0; in_ready low exactly during EMIT.
- Backpressure: hold out_ready = 0 for 5 cycles in EMIT -> all out_* fields stable, in_ready = 0 throughout; a beat offered during EMIT is not accepted; the next packet is accepted the cycle after the handshake.
- LEN_W=2, mode=1, 6-beat packet [0x10, 0x1F, 0x1E, 0x1D, 0x1C, 0x2F(last)] -> count saturates at 3, mismatch = 1 (beat 0x1F), out_max = 0x2F, err = 0.
- Assert rst for 1 cycle after 2 beats of a packet -> no out_valid; a fresh packet [0x07(last)] then returns out_max = 0x07, count = 1; mode toggled mid-packet has no effect on the result.
